// File: rtl/cac_scan_if.sv
// Candidate-table scan bus: table write ports, scan start and scan results.
// The master side (BIRA analysis FSM) writes entries and starts scans;
// the slave side (cac_scan_ctrl) owns the table and reports results.
interface cac_scan_if #(
    parameter int NR     = 4,
    parameter int NC     = 4,
    parameter int ADDR_W = 10,
    parameter int BNK_W  = 2
);
    localparam int RI_W = $clog2(NR);
    localparam int CI_W = $clog2(NC);
    localparam int HC_W = $clog2(NR * NC + 1);

    logic              row_wr;
    logic [RI_W-1:0]   row_idx;
    logic [ADDR_W-1:0] row_addr;
    logic [BNK_W-1:0]  row_bnk;
    logic              col_wr;
    logic [CI_W-1:0]   col_idx;
    logic [ADDR_W-1:0] col_addr;
    logic [BNK_W-1:0]  col_bnk;
    logic              start;
    logic              busy;
    logic              done;
    logic [NR*NC-1:0]  hit_matrix;
    logic [HC_W-1:0]   hit_cnt;
    logic              first_vld;
    logic [RI_W-1:0]   first_row;
    logic [CI_W-1:0]   first_col;

    modport master (
        output row_wr, row_idx, row_addr, row_bnk,
        output col_wr, col_idx, col_addr, col_bnk,
        output start,
        input  busy, done, hit_matrix, hit_cnt, first_vld, first_row, first_col
    );

    modport slave (
        input  row_wr, row_idx, row_addr, row_bnk,
        input  col_wr, col_idx, col_addr, col_bnk,
        input  start,
        output busy, done, hit_matrix, hit_cnt, first_vld, first_row, first_col
    );
endinterface

// File: rtl/cac_scan_ctrl.sv
// Candidate address comparator scan sequencer.
// Sweeps one shared comparator over every (row, column) candidate pair,
// one pair per cycle, and reports hit matrix, hit count and first hit.
// Optional macro CAC_EARLY_ABORT_EN: stop the sweep on the first match.
module cac_scan_ctrl #(
    parameter int NR     = 4,
    parameter int NC     = 4,
    parameter int ADDR_W = 10,
    parameter int BNK_W  = 2
) (
    input  logic        clk,
    input  logic        rst,
    cac_scan_if.slave   bus
);
    localparam int RI_W = $clog2(NR);
    localparam int CI_W = $clog2(NC);
    localparam int PI_W = RI_W + CI_W;
    localparam int HC_W = $clog2(NR * NC + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [ADDR_W-1:0] row_addr_q [NR];
    logic [BNK_W-1:0]  row_bnk_q  [NR];
    logic [ADDR_W-1:0] col_addr_q [NC];
    logic [BNK_W-1:0]  col_bnk_q  [NC];

    logic [1:0]       state_q, state_d;
    logic [RI_W-1:0]  r_q, r_d;
    logic [CI_W-1:0]  c_q, c_d;
    logic [NR*NC-1:0] hm_q, hm_d;
    logic [HC_W-1:0]  cnt_q, cnt_d;
    logic             fv_q, fv_d;
    logic [RI_W-1:0]  fr_q, fr_d;
    logic [CI_W-1:0]  fc_q, fc_d;

    logic             pair_hit;
    logic             last_pair;
    logic [PI_W-1:0]  pair_idx;

    // Shared comparator: both tags valid, same bank, same address.
    assign pair_hit  = (row_bnk_q[r_q] != '0) && (col_bnk_q[c_q] != '0) &&
                       (row_bnk_q[r_q] == col_bnk_q[c_q]) &&
                       (row_addr_q[r_q] == col_addr_q[c_q]);
    assign last_pair = (r_q == RI_W'(NR - 1)) && (c_q == CI_W'(NC - 1));
    // Power-of-2 table sizes make {r,c} equal to r*NC+c.
    assign pair_idx  = {r_q, c_q};

    // Candidate table: writable only while idle so a scan sees a stable table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                row_addr_q[i] <= '0;
                row_bnk_q[i]  <= '0;
            end
            for (int j = 0; j < NC; j++) begin
                col_addr_q[j] <= '0;
                col_bnk_q[j]  <= '0;
            end
        end else if (state_q == ST_IDLE) begin
            if (bus.row_wr) begin
                row_addr_q[bus.row_idx] <= bus.row_addr;
                row_bnk_q[bus.row_idx]  <= bus.row_bnk;
            end
            if (bus.col_wr) begin
                col_addr_q[bus.col_idx] <= bus.col_addr;
                col_bnk_q[bus.col_idx]  <= bus.col_bnk;
            end
        end
    end

    // Scan sequencing and result accumulation.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        hm_d    = hm_q;
        cnt_d   = cnt_q;
        fv_d    = fv_q;
        fr_d    = fr_q;
        fc_d    = fc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SCAN;
                    r_d     = '0;
                    c_d     = '0;
                    hm_d    = '0;
                    cnt_d   = '0;
                    fv_d    = 1'b0;
                    fr_d    = '0;
                    fc_d    = '0;
                end
            end
            ST_SCAN: begin
                c_d = c_q + CI_W'(1);
                if (c_q == CI_W'(NC - 1)) begin
                    r_d = r_q + RI_W'(1);
                end
                if (last_pair) begin
                    state_d = ST_DONE;
                end
                if (pair_hit) begin
                    hm_d[pair_idx] = 1'b1;
                    cnt_d          = cnt_q + HC_W'(1);
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        fr_d = r_q;
                        fc_d = c_q;
`ifdef CAC_EARLY_ABORT_EN
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset returns everything to idle/zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            hm_q    <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            fr_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            hm_q    <= hm_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            fr_q    <= fr_d;
            fc_q    <= fc_d;
        end
    end

    assign bus.busy       = (state_q == ST_SCAN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.hit_matrix = hm_q;
    assign bus.hit_cnt    = cnt_q;
    assign bus.first_vld  = fv_q;
    assign bus.first_row  = fr_q;
    assign bus.first_col  = fc_q;
endmodule

// File: tb/tb_cac_scan_ctrl.sv
// Self-checking bench for cac_scan_ctrl: directed cases plus randomized
// table contents and scans, compared cycle by cycle to a behavioural model.
module tb_cac_scan_ctrl;
    localparam int NR = 4, NC = 4, ADDR_W = 10, BNK_W = 2, NP = NR * NC;
    localparam int RI_W = $clog2(NR), CI_W = $clog2(NC);
`ifdef CAC_EARLY_ABORT_EN
    localparam bit EA = 1'b1;
`else
    localparam bit EA = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cac_scan_if #(.NR(NR), .NC(NC), .ADDR_W(ADDR_W), .BNK_W(BNK_W)) bus ();
    cac_scan_ctrl #(.NR(NR), .NC(NC), .ADDR_W(ADDR_W), .BNK_W(BNK_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [ADDR_W-1:0] m_ra [NR];
    logic [BNK_W-1:0]  m_rb [NR];
    logic [ADDR_W-1:0] m_ca [NC];
    logic [BNK_W-1:0]  m_cb [NC];
    int               m_left = 0;   // scan cycles still to run
    bit               m_done = 1'b0;
    logic [NP-1:0]    m_hm = '0;
    int               m_cnt = 0;
    bit               m_fv = 1'b0;
    int               m_fr = 0, m_fc = 0;
    bit               chk_en = 1'b0;

    // Final result of a scan computed directly from the table contents.
    function void m_scan();
        int first;
        first = -1;
        m_hm = '0; m_cnt = 0; m_fv = 1'b0; m_fr = 0; m_fc = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (m_rb[r] != 0 && m_cb[c] != 0 && m_ra[r] == m_ca[c] && m_rb[r] == m_cb[c]) begin
                    m_hm[r*NC+c] = 1'b1;
                    m_cnt++;
                    if (first < 0) begin
                        first = r * NC + c; m_fv = 1'b1; m_fr = r; m_fc = c;
                    end
                end
        m_left = NP;
        if (EA && first >= 0) begin
            m_hm = '0; m_hm[first] = 1'b1; m_cnt = 1; m_left = first + 1;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin m_ra[i] = '0; m_rb[i] = '0; end
            for (int j = 0; j < NC; j++) begin m_ca[j] = '0; m_cb[j] = '0; end
            m_left = 0; m_done = 1'b0; m_hm = '0; m_cnt = 0; m_fv = 1'b0; m_fr = 0; m_fc = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else begin
            if (bus.row_wr) begin m_ra[bus.row_idx] = bus.row_addr; m_rb[bus.row_idx] = bus.row_bnk; end
            if (bus.col_wr) begin m_ca[bus.col_idx] = bus.col_addr; m_cb[bus.col_idx] = bus.col_bnk; end
            if (bus.start) m_scan();
        end
    end

    // Compare process: handshake every cycle, results whenever not scanning.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", bus.busy, 32'(m_left > 0));
            chk("done", bus.done, 32'(m_done));
            if (m_left == 0) begin
                chk("hit_matrix", bus.hit_matrix, m_hm);
                chk("hit_cnt", bus.hit_cnt, m_cnt);
                chk("first_vld", bus.first_vld, m_fv);
                chk("first_row", bus.first_row, m_fr);
                chk("first_col", bus.first_col, m_fc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input bit dr, input int ri, input int ra, input int rb,
                      input bit dc, input int ci, input int ca, input int cb);
        bus.row_wr = dr; bus.row_idx = RI_W'(ri); bus.row_addr = ADDR_W'(ra); bus.row_bnk = BNK_W'(rb);
        bus.col_wr = dc; bus.col_idx = CI_W'(ci); bus.col_addr = ADDR_W'(ca); bus.col_bnk = BNK_W'(cb);
        @(posedge clk); #1;
        bus.row_wr = 1'b0; bus.col_wr = 1'b0;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < NR; i++) wr(1'b1, i, 0, 0, 1'b1, i, 0, 0);
    endtask

    // Start a scan (any write already on the bus goes in with it), optionally
    // inject start+row write or rst at scan cycle inj/rst_at, count busy cycles.
    task automatic run_scan(input int inj, input int rst_at, output int ncyc, output bit seen);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.row_wr = 1'b0; bus.col_wr = 1'b0;
        ncyc = 0; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1'b1; break; end
            if (bus.busy) ncyc++;
            bus.start = (k == inj);
            bus.row_wr = (k == inj); bus.row_idx = RI_W'(NR - 1);
            bus.row_addr = '0; bus.row_bnk = '0;
            rst = (k == rst_at);
        end
        bus.start = 1'b0; bus.row_wr = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    int  n;
    bit  seen;

    initial begin
        bus.start = 1'b0;
        wr(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hm", bus.hit_matrix, 0);
        chk("rst_cnt", bus.hit_cnt, 0);
        chk("rst_fv", bus.first_vld, 0);

        // Empty table: full sweep, no hits.
        run_scan(-1, -1, n, seen);
        chk("empty_seen", seen, 1);
        chk("empty_len", n, 16);
        chk("empty_hm", bus.hit_matrix, 0);

        // Single hit at pair (1,2).
        wr(1'b1, 1, 'h155, 2, 1'b1, 2, 'h155, 2);
        run_scan(-1, -1, n, seen);
        chk("one_len", n, EA ? 7 : 16);
        chk("one_hm", bus.hit_matrix, 32'h0040);
        chk("one_cnt", bus.hit_cnt, 1);
        chk("one_first", {bus.first_vld, bus.first_row, bus.first_col}, {1'b1, 2'd1, 2'd2});

        // Bank mismatch and invalid tags never match.
        clear_tbl();
        wr(1'b1, 0, 'h3A, 1, 1'b1, 0, 'h3A, 2);
        wr(1'b1, 3, 0, 0, 1'b1, 3, 0, 0);
        run_scan(-1, -1, n, seen);
        chk("neg_cnt", bus.hit_cnt, 0);
        chk("neg_fv", bus.first_vld, 0);

        // Everything matches.
        for (int i = 0; i < NR; i++) wr(1'b1, i, 'h2AA, 3, 1'b1, i, 'h2AA, 3);
        run_scan(-1, -1, n, seen);
        chk("all_len", n, EA ? 1 : 16);
        chk("all_hm", bus.hit_matrix, EA ? 32'h0001 : 32'hFFFF);
        chk("all_cnt", bus.hit_cnt, EA ? 1 : 16);
        chk("all_first", {bus.first_row, bus.first_col}, 0);

        // Start and row write mid-scan are ignored; only match is the last pair.
        clear_tbl();
        wr(1'b1, 3, 'h11, 1, 1'b1, 3, 'h11, 1);
        run_scan(3, -1, n, seen);
        chk("ign_len", n, 16);
        chk("ign_hm", bus.hit_matrix, 32'h8000);
        chk("ign_first", {bus.first_row, bus.first_col}, 4'hF);

        // rst at scan cycle 5: no done, results and table cleared.
        run_scan(-1, 4, n, seen);
        chk("rst_nodone", seen, 0);
        chk("rst_len", n, 5);
        chk("rst_mid_hm", bus.hit_matrix, 0);
        run_scan(-1, -1, n, seen);
        chk("rst_tbl_cnt", bus.hit_cnt, 0);

        // Write in the same cycle as start is seen by the scan.
        bus.row_wr = 1'b1; bus.row_idx = 2'd2; bus.row_addr = 10'h0AB; bus.row_bnk = 2'd1;
        bus.col_wr = 1'b1; bus.col_idx = 2'd1; bus.col_addr = 10'h0AB; bus.col_bnk = 2'd1;
        run_scan(-1, -1, n, seen);
        chk("sw_hm", bus.hit_matrix, 32'h0200);

        // Randomized tables and scans, sometimes with ignored mid-scan pokes.
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++)
                wr(1'($urandom_range(0, 1)), $urandom_range(0, NR - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), $urandom_range(0, NC - 1), $urandom_range(0, 3), $urandom_range(0, 3));
            run_scan(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1, -1, n, seen);
            chk("rnd_seen", seen, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
